accumulator_bank: RTL and testbench
===================================

# accumulator_bank

Parametrised multi-channel accumulator: the next generation of the single 8-bit accumulator. It holds `CHANNELS` independent running sums of `WIDTH` bits. Each sum can wrap or saturate, and each carries a sticky overflow flag. Operations arrive over a valid/ready handshake, and each accepted operation produces a one-cycle result pulse. The block sits between the input decoder and the display/readout logic, which polls sums through a combinational read port.

## Interface
Parameters:
- `WIDTH`, 8: bits per accumulator and per operand.
- `CHANNELS`, 4: number of accumulators, ≥1.
- `SATURATE`, 0: 0 = wrap modulo 2^WIDTH; 1 = clamp unsigned at 2^WIDTH−1.

Ports:
- `clk`  in  1  single clock, all state updates on posedge.
- `CLR_n`  in  1  asynchronous, active-low reset of all state.
- `CLR`  in  1  synchronous clear of all channels and flags.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block can accept; equals `!CLR`.
- `in_op`  in  2  00 ADD, 01 LOAD, 10 CLEAR, 11 NOP.
- `in_ch`  in  CW=max(1,$clog2(CHANNELS))  target channel.
- `D`  in  WIDTH  operand.
- `res_valid`  out  1  one-cycle pulse, the cycle after accept.
- `res_ch`  out  CW  channel of the result.
- `res_data`  out  WIDTH  channel value after the operation.
- `res_ovf`  out  1  channel overflow flag after the operation.
- `rd_ch`  in  CW  readback select.
- `rd_data`  out  WIDTH  current value of `acc[rd_ch]`, combinational from registers; 0 if `rd_ch` ≥ CHANNELS.
- `ovf`  out  CHANNELS  sticky overflow flag per channel.

## Operation
- An operation is accepted on a posedge where `in_valid && in_ready`.
- ADD: sum = {1'b0,acc}+{1'b0,D}, computed at WIDTH+1 bits.
  - If sum[WIDTH]=1, the channel `ovf` bit is set.
  - Wrap mode: acc ← sum[WIDTH-1:0].
  - Saturate mode: acc ← all-ones on carry, else sum.
- LOAD: acc ← D; `ovf` for the channel is unchanged.
- CLEAR: acc ← 0 and the channel `ovf` ← 0.
- NOP: no state change.
- `in_ch` ≥ CHANNELS: treated as NOP. The result still pulses, with `res_data`=0 and `res_ovf`=0.
- `ovf` bits stay set until a CLEAR of that channel, `CLR`, or `CLR_n`.
- `CLR`=1: all acc and `ovf` go to 0 on the next edge. `in_ready`=0, so no operation is accepted in that cycle (CLR wins). `res_valid` is 0 in the following cycle.
- Back-to-back operations to the same channel are legal. Each edge does a full read-modify-write, so there are no hazards and no stall.

## Timing
- Reset (`CLR_n`=0, asynchronous) drives all registers and outputs to 0:
  - acc[*]=0, `ovf`=0, `res_valid`=0, `res_ch`=0, `res_data`=0, `res_ovf`=0.
  - `in_ready` follows `CLR`.
- Deassertion of `CLR_n` is synchronised externally.
- Accept at edge t: acc is updated at edge t; `res_*` are registered at edge t and valid for the cycle t→t+1. Latency is 1 cycle.
- `rd_data` reflects the new value in the cycle after edge t. A read of the same channel in the accept cycle returns the old value.
- Throughput is one operation per cycle. `in_ready` is independent of `in_valid`.
- Asserting `CLR_n` mid-stream discards any pending result: `res_valid` drops immediately.

## Structure
- Package `accum_pkg`:
  - `typedef enum logic [1:0] {OP_ADD, OP_LOAD, OP_CLEAR, OP_NOP} accum_op_e`.
  - Function `ch_width(int n)` returning max(1,$clog2(n)).
- Sub-module `accum_sat_add`: combinational, parametrised by WIDTH and SATURATE. Inputs are a, b; outputs are sum and carry. It is instantiated once and shared by all channels, since at most one operation occurs per cycle.
- Storage is an array acc[CHANNELS] plus an `ovf` vector, in one always_ff with async reset.

## Test plan
- Reset, then ADD ch0 D=5 three times → `res_data` 5, 10, 15 on consecutive cycles; `rd_data`(rd_ch=0)=15; `ovf`=0.
- SATURATE=0: LOAD ch1 250, ADD ch1 10 → `res_data`=4, `res_ovf`=1, `ovf[1]`=1. A further ADD 1 → 5, and `ovf[1]` stays 1.
- SATURATE=1: LOAD ch2 250, ADD ch2 10 → `res_data`=255, `ovf[2]`=1. CLEAR ch2 → `res_data`=0, `ovf[2]`=0.
- `CLR`=1 with `in_valid`=1 ADD ch3 7 → `in_ready`=0, no `res_valid` next cycle, all acc=0, `ovf`=0.
- `in_ch`=5 with CHANNELS=4 (CW=2 wraps; use CHANNELS=5, `in_ch`=6 with CW=3) → `res_valid`=1, `res_data`=0, no channel modified.
- Mid-stream `CLR_n` pulse between two ADDs → outputs 0 immediately; ADD ch0 3 after release → `res_data`=3.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and helpers for the multi-channel accumulator bank.
package accum_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_NOP   = 2'b11
    } accum_op_e;

    // Channel-select width; never narrower than one bit so a single channel still has a port.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/accum_sat_add.sv
// Unsigned adder with carry-out and optional clamp to all-ones on overflow.
module accum_sat_add #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};
    assign carry  = w_full[WIDTH];
    assign sum    = ((SATURATE != 0) && carry) ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];

endmodule

// File: rtl/accumulator_bank.sv
// Bank of independent running sums with sticky overflow, one-cycle result pulse
// and a combinational readback port.
module accumulator_bank
    import accum_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int SATURATE = 0,
    localparam int CW       = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                CLR_n,
    input  logic                CLR,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [CW-1:0]       in_ch,
    input  logic [WIDTH-1:0]    D,
    output logic                res_valid,
    output logic [CW-1:0]       res_ch,
    output logic [WIDTH-1:0]    res_data,
    output logic                res_ovf,
    input  logic [CW-1:0]       rd_ch,
    output logic [WIDTH-1:0]    rd_data,
    output logic [CHANNELS-1:0] ovf
);

    logic [WIDTH-1:0]    r_acc [CHANNELS];
    logic [CHANNELS-1:0] r_ovf;
    logic                r_res_valid;
    logic [CW-1:0]       r_res_ch;
    logic [WIDTH-1:0]    r_res_data;
    logic                r_res_ovf;

    logic                w_ch_ok;
    logic                w_rd_ok;
    logic [WIDTH-1:0]    w_cur;
    logic                w_cur_ovf;
    logic [WIDTH-1:0]    w_sum;
    logic                w_carry;
    logic [WIDTH-1:0]    w_nxt_acc;
    logic                w_nxt_ovf;

    assign w_ch_ok   = int'(in_ch) < CHANNELS;
    assign w_rd_ok   = int'(rd_ch) < CHANNELS;
    assign w_cur     = w_ch_ok ? r_acc[in_ch] : '0;
    assign w_cur_ovf = w_ch_ok ? r_ovf[in_ch] : 1'b0;

    // One adder serves every channel because at most one operation lands per cycle.
    accum_sat_add #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_add (
        .a     (w_cur),
        .b     (D),
        .sum   (w_sum),
        .carry (w_carry)
    );

    always_comb begin
        w_nxt_acc = w_cur;
        w_nxt_ovf = w_cur_ovf;
        case (accum_op_e'(in_op))
            OP_ADD: begin
                w_nxt_acc = w_sum;
                w_nxt_ovf = w_cur_ovf | w_carry;
            end
            OP_LOAD:  w_nxt_acc = D;
            OP_CLEAR: begin
                w_nxt_acc = '0;
                w_nxt_ovf = 1'b0;
            end
            default: ;
        endcase
        if (!w_ch_ok) begin
            w_nxt_acc = '0;
            w_nxt_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
            r_ovf       <= '0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_data  <= '0;
            r_res_ovf   <= 1'b0;
        end else if (CLR) begin
            for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
            r_ovf       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= in_valid;
            if (in_valid) begin
                r_res_ch   <= in_ch;
                r_res_data <= w_nxt_acc;
                r_res_ovf  <= w_nxt_ovf;
                if (w_ch_ok) begin
                    r_acc[in_ch] <= w_nxt_acc;
                    r_ovf[in_ch] <= w_nxt_ovf;
                end
            end
        end
    end

    assign in_ready  = !CLR;
    assign res_valid = r_res_valid;
    assign res_ch    = r_res_ch;
    assign res_data  = r_res_data;
    assign res_ovf   = r_res_ovf;
    assign ovf       = r_ovf;
    assign rd_data   = w_rd_ok ? r_acc[rd_ch] : '0;

endmodule

// File: tb/tb_accumulator_bank.sv
// Scoreboard bench: a wrap-mode 4-channel bank and a saturating 5-channel bank.
module tb_accumulator_bank;

    localparam logic [1:0] OPADD = 2'b00, OPLOAD = 2'b01, OPCLR = 2'b10, OPNOP = 2'b11;

    typedef struct {
        logic [2:0] ch;
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clr_a, vld_a, clr_b, vld_b;
    logic [1:0] op_a, op_b;
    logic [1:0] ch_a, rdch_a;
    logic [2:0] ch_b, rdch_b;
    logic [7:0] d_a, d_b;

    logic       rdy_a, rv_a, ro_a, rdy_b, rv_b, ro_b;
    logic [1:0] rc_a;
    logic [2:0] rc_b;
    logic [7:0] rdat_a, rdd_a, rdat_b, rdd_b;
    logic [3:0] ovf_a;
    logic [4:0] ovf_b;

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;

    accumulator_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) dut_a (
        .clk(clk), .CLR_n(rst_n), .CLR(clr_a), .in_valid(vld_a), .in_ready(rdy_a),
        .in_op(op_a), .in_ch(ch_a), .D(d_a), .res_valid(rv_a), .res_ch(rc_a),
        .res_data(rdat_a), .res_ovf(ro_a), .rd_ch(rdch_a), .rd_data(rdd_a), .ovf(ovf_a)
    );

    accumulator_bank #(.WIDTH(8), .CHANNELS(5), .SATURATE(1)) dut_b (
        .clk(clk), .CLR_n(rst_n), .CLR(clr_b), .in_valid(vld_b), .in_ready(rdy_b),
        .in_op(op_b), .in_ch(ch_b), .D(d_b), .res_valid(rv_b), .res_ch(rc_b),
        .res_data(rdat_b), .res_ovf(ro_b), .rd_ch(rdch_b), .rd_data(rdd_b), .ovf(ovf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_a(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] d,
                           input logic [7:0] ed, input logic eo);
        exp_t e;
        @(negedge clk);
        vld_a = 1'b1; op_a = op; ch_a = ch; d_a = d;
        e.ch = {1'b0, ch}; e.data = ed; e.ovf = eo;
        qa.push_back(e);
    endtask

    task automatic drive_b(input logic [1:0] op, input logic [2:0] ch, input logic [7:0] d,
                           input logic [7:0] ed, input logic eo);
        exp_t e;
        @(negedge clk);
        vld_b = 1'b1; op_b = op; ch_b = ch; d_b = d;
        e.ch = ch; e.data = ed; e.ovf = eo;
        qb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        vld_a = 1'b0;
        vld_b = 1'b0;
    endtask

    task automatic rd_a(input string nm, input logic [1:0] ch, input logic [7:0] req);
        rdch_a = ch;
        #1;
        chk(nm, 32'(rdd_a), 32'(req));
    endtask

    task automatic rd_b(input string nm, input logic [2:0] ch, input logic [7:0] req);
        rdch_b = ch;
        #1;
        chk(nm, 32'(rdd_b), 32'(req));
    endtask

    initial begin
        rst_n = 1'b0;
        clr_a = 1'b0; vld_a = 1'b0; op_a = OPNOP; ch_a = '0; d_a = '0; rdch_a = '0;
        clr_b = 1'b0; vld_b = 1'b0; op_b = OPNOP; ch_b = '0; d_b = '0; rdch_b = '0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rv_a === 1'b1) begin
                        if (qa.size() == 0) chk("res_a_unexpected", 32'(rv_a), 32'(0));
                        else begin
                            e = qa.pop_front();
                            chk("res_a_ch",   32'(rc_a),   32'(e.ch));
                            chk("res_a_data", 32'(rdat_a), 32'(e.data));
                            chk("res_a_ovf",  32'(ro_a),   32'(e.ovf));
                        end
                    end
                    if (rv_b === 1'b1) begin
                        if (qb.size() == 0) chk("res_b_unexpected", 32'(rv_b), 32'(0));
                        else begin
                            e = qb.pop_front();
                            chk("res_b_ch",   32'(rc_b),   32'(e.ch));
                            chk("res_b_data", 32'(rdat_b), 32'(e.data));
                            chk("res_b_ovf",  32'(ro_b),   32'(e.ovf));
                        end
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_res_valid", 32'(rv_a),   32'(0));
        chk("rst_res_ch",    32'(rc_a),   32'(0));
        chk("rst_res_data",  32'(rdat_a), 32'(0));
        chk("rst_res_ovf",   32'(ro_a),   32'(0));
        chk("rst_ovf",       32'(ovf_a),  32'(0));
        chk("rst_in_ready",  32'(rdy_a),  32'(1));
        chk("rst_rd_data",   32'(rdd_a),  32'(0));
        chk("rst_b_valid",   32'(rv_b),   32'(0));
        chk("rst_b_ovf",     32'(ovf_b),  32'(0));
        rst_n = 1'b1;

        // Back-to-back accumulation on one channel
        drive_a(OPADD, 2'd0, 8'd5, 8'd5,  1'b0);
        drive_a(OPADD, 2'd0, 8'd5, 8'd10, 1'b0);
        drive_a(OPADD, 2'd0, 8'd5, 8'd15, 1'b0);
        idle();
        rd_a("rd_ch0_sum", 2'd0, 8'd15);
        chk("ovf_after_sum", 32'(ovf_a), 32'(0));

        // Wrap with sticky overflow
        drive_a(OPLOAD, 2'd1, 8'd250, 8'd250, 1'b0);
        drive_a(OPADD,  2'd1, 8'd10,  8'd4,   1'b1);
        idle();
        chk("ovf_wrap_set", 32'(ovf_a), 32'(4'b0010));
        drive_a(OPADD,  2'd1, 8'd1,   8'd5,   1'b1);
        idle();
        chk("ovf_wrap_sticky", 32'(ovf_a), 32'(4'b0010));
        rd_a("rd_ch1_wrap", 2'd1, 8'd5);

        // LOAD then NOP reports the held value
        drive_a(OPLOAD, 2'd3, 8'd9, 8'd9, 1'b0);
        drive_a(OPNOP,  2'd3, 8'd0, 8'd9, 1'b0);
        idle();
        rd_a("rd_ch3_nop", 2'd3, 8'd9);

        // Synchronous clear wins over an offered ADD
        @(negedge clk);
        clr_a = 1'b1; vld_a = 1'b1; op_a = OPADD; ch_a = 2'd3; d_a = 8'd7;
        #1;
        chk("clr_in_ready", 32'(rdy_a), 32'(0));
        @(negedge clk);
        clr_a = 1'b0; vld_a = 1'b0;
        chk("clr_no_result", 32'(rv_a), 32'(0));
        for (int i = 0; i < 4; i++) rd_a("clr_rd_acc", 2'(i), 8'd0);
        chk("clr_ovf", 32'(ovf_a), 32'(0));

        // Async reset drops a pending result immediately
        drive_a(OPADD, 2'd0, 8'd3, 8'd3, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 32'(rv_a), 32'(1));
        rst_n = 1'b0;
        vld_a = 1'b0;
        #1;
        chk("midrst_valid", 32'(rv_a),   32'(0));
        chk("midrst_data",  32'(rdat_a), 32'(0));
        rd_a("midrst_rd_ch0", 2'd0, 8'd0);
        qa.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(OPADD, 2'd0, 8'd3, 8'd3, 1'b0);
        idle();
        rd_a("postrst_rd_ch0", 2'd0, 8'd3);

        // Saturating bank
        drive_b(OPLOAD, 3'd2, 8'd250, 8'd250, 1'b0);
        drive_b(OPADD,  3'd2, 8'd10,  8'd255, 1'b1);
        idle();
        chk("sat_ovf_set", 32'(ovf_b), 32'(5'b00100));
        rd_b("sat_rd_ch2", 3'd2, 8'd255);
        drive_b(OPCLR,  3'd2, 8'd0,   8'd0,   1'b0);
        idle();
        chk("sat_ovf_cleared", 32'(ovf_b), 32'(0));

        // Out-of-range channel acts as NOP yet still reports
        drive_b(OPLOAD, 3'd0, 8'd77,  8'd77,  1'b0);
        drive_b(OPADD,  3'd6, 8'd9,   8'd0,   1'b0);
        drive_b(OPADD,  3'd0, 8'd100, 8'd177, 1'b0);
        drive_b(OPADD,  3'd0, 8'd100, 8'd255, 1'b1);
        idle();
        rd_b("oor_rd_ch0", 3'd0, 8'd255);
        rd_b("oor_rd_ch6", 3'd6, 8'd0);
        rd_b("oor_rd_ch2", 3'd2, 8'd0);
        chk("oor_ovf", 32'(ovf_b), 32'(5'b00001));

        repeat (3) @(negedge clk);
        chk("qa_drained", 32'(qa.size()), 32'(0));
        chk("qb_drained", 32'(qb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
